// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the RV32I instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus plus the decode-side valid/ready port.
interface fetch_unit_if #(
  parameter int unsigned N_param = 32
) ();

  logic               imem_req_o;
  logic [31:0]        imem_addr_o;
  logic               imem_gnt_i;
  logic               imem_rvalid_i;
  logic [N_param-1:0] imem_rdata_i;

  logic [N_param-1:0] instruction_o;
  logic [31:0]        pc_o;
  logic               valid_o;
  logic               ready_i;

  modport master (
    output imem_req_o, imem_addr_o, instruction_o, pc_o, valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instruction_o, pc_o, valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_i
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Reservation FIFO: entries are reserved at grant with their pc, filled in order
// by responses, and popped from the head once filled.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned N_param    = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               flush_i,
  input  logic               reserve_i,
  input  logic [31:0]        reserve_pc_i,
  input  logic               fill_i,
  input  logic [N_param-1:0] fill_data_i,
  input  logic               pop_i,
  output logic [CW-1:0]      count_o,
  output logic [CW-1:0]      outstanding_o,
  output logic [31:0]        head_pc_o,
  output logic [N_param-1:0] head_data_o,
  output logic               head_filled_o
);

  localparam int unsigned IW = $clog2(FIFO_DEPTH);

  logic [CW-1:0]         head_q;
  logic [CW-1:0]         fill_q;
  logic [CW-1:0]         tail_q;
  logic [31:0]           pc_q     [FIFO_DEPTH];
  logic [N_param-1:0]    data_q   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] filled_q;

  logic [IW-1:0] head_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] tail_idx;

  assign head_idx = head_q[IW-1:0];
  assign fill_idx = fill_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  // head <= fill <= tail; the extra pointer bit separates full from empty.
  assign count_o       = tail_q - head_q;
  assign outstanding_o = tail_q - fill_q;
  assign head_pc_o     = pc_q[head_idx];
  assign head_data_o   = data_q[head_idx];
  assign head_filled_o = filled_q[head_idx];

  // Reserve, fill and pop never touch the same slot in one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q   <= '0;
      fill_q   <= '0;
      tail_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_q[i]   <= RESET_PC;
        data_q[i] <= N_param'(INST_NOP);
      end
    end else if (flush_i) begin
      head_q   <= '0;
      fill_q   <= '0;
      tail_q   <= '0;
      filled_q <= '0;
    end else begin
      if (reserve_i) begin
        pc_q[tail_idx]     <= reserve_pc_i;
        filled_q[tail_idx] <= 1'b0;
        tail_q             <= tail_q + CW'(1);
      end
      if (fill_i) begin
        data_q[fill_idx]   <= fill_data_i;
        filled_q[fill_idx] <= 1'b1;
        fill_q             <= fill_q + CW'(1);
      end
      if (pop_i) begin
        filled_q[head_idx] <= 1'b0;
        head_q             <= head_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the pc, issues word fetches, buffers responses and
// discards stale responses after a redirect from execute.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned N_param    = 32,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  fetch_unit_if.master bus
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e       state_q;
  logic [31:0]        pc_q;
  logic [CW-1:0]      discard_q;

  logic               run;
  logic               can_reserve;
  logic               req;
  logic               grant;
  logic               rsp_live;
  logic               fill;
  logic               pop;
  logic               stale_grant;
  logic [CW-1:0]      count;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      redirect_cnt_d;
  logic [CW-1:0]      drain_cnt_d;
  logic [31:0]        head_pc;
  logic [N_param-1:0] head_data;
  logic               head_filled;

  assign run         = (state_q == FETCH_RUN);
  assign can_reserve = (count < DEPTH_C);
  assign req         = ~i_rst & run & i_en & can_reserve & ~redirect_i;
  assign grant       = req & bus.imem_gnt_i;
  assign rsp_live    = bus.imem_rvalid_i & (outstanding != '0);
  assign fill        = run & rsp_live & ~redirect_i;
  assign pop         = head_filled & bus.ready_i & ~redirect_i;

  // A grant that lands with a redirect still belongs to the old path and must be drained.
  assign stale_grant    = run & i_en & can_reserve & bus.imem_gnt_i;
  assign redirect_cnt_d = outstanding + CW'(stale_grant) - CW'(rsp_live);
  assign drain_cnt_d    = discard_q - CW'(bus.imem_rvalid_i & (discard_q != '0));

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = pc_q;
  assign bus.valid_o       = head_filled;
  assign bus.instruction_o = head_data;
  assign bus.pc_o          = head_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= FETCH_RUN;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else if (run) begin
      if (redirect_i) begin
        pc_q      <= align_pc(redirect_pc_i);
        discard_q <= redirect_cnt_d;
        state_q   <= (redirect_cnt_d != '0) ? FETCH_DRAIN : FETCH_RUN;
      end else if (grant) begin
        pc_q <= pc_q + 32'd4;
      end
    end else begin
      // Draining: a further redirect only retargets the pc.
      discard_q <= drain_cnt_d;
      if (redirect_i) begin
        pc_q <= align_pc(redirect_pc_i);
      end
      if (drain_cnt_d == '0) begin
        state_q <= FETCH_RUN;
      end
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(run && bus.imem_rvalid_i && (outstanding == '0)));
    end
  end

  fetch_fifo #(
    .N_param    (N_param),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RESET_PC   (RESET_PC)
  ) u_fifo (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .flush_i       (redirect_i),
    .reserve_i     (grant),
    .reserve_pc_i  (pc_q),
    .fill_i        (fill),
    .fill_data_i   (bus.imem_rdata_i),
    .pop_i         (pop),
    .count_o       (count),
    .outstanding_o (outstanding),
    .head_pc_o     (head_pc),
    .head_data_o   (head_data),
    .head_filled_o (head_filled)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned N = 32;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  fetch_unit_if #(.N_param(N)) bus ();

  fetch_unit #(
    .N_param    (N),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus)
  );

  always #5 i_clk = ~i_clk;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  int          lat;
  int          vcnt;
  int          gcnt;
  logic        en_s, redir_s, ready_s, force_gnt_s;
  logic [31:0] rpc_s;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_ins[$];
  logic        req_log   [1024];
  logic        valid_log [1024];
  logic [31:0] addr_log  [1024];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] obs_pc_at(input int i);
    return (i < obs_pc.size()) ? obs_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] obs_ins_at(input int i);
    return (i < obs_ins.size()) ? obs_ins[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply controls, run the memory model, log outputs, advance.
  task automatic tick();
    cyc++;
    i_en          = en_s;
    redirect_i    = redir_s;
    redirect_pc_i = rpc_s;
    bus.ready_i   = ready_s;
    #1;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(mq_addr[0]);
      mq_addr.delete(0);
      mq_due.delete(0);
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
    end
    bus.imem_gnt_i = bus.imem_req_o | force_gnt_s;
    if (bus.imem_gnt_i) begin
      mq_addr.push_back(bus.imem_addr_o);
      mq_due.push_back(cyc + lat);
    end
    #1;
    req_log[cyc]   = bus.imem_req_o;
    addr_log[cyc]  = bus.imem_addr_o;
    valid_log[cyc] = bus.valid_o;
    if (bus.valid_o) vcnt++;
    if (bus.imem_req_o && bus.imem_gnt_i) gcnt++;
    if (bus.valid_o && bus.ready_i && !redirect_i) begin
      obs_pc.push_back(bus.pc_o);
      obs_ins.push_back(bus.instruction_o);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req"},   32'(bus.imem_req_o), 32'd0);
    check_eq({pfx, "_addr"},  bus.imem_addr_o, 32'h0000_0000);
    check_eq({pfx, "_valid"}, 32'(bus.valid_o), 32'd0);
    check_eq({pfx, "_instr"}, bus.instruction_o, INST_NOP);
    check_eq({pfx, "_pc"},    bus.pc_o, 32'h0000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c, r, d, e;
    n_cmp = 0; n_bad = 0; cyc = 0; lat = 1; vcnt = 0; gcnt = 0;
    en_s = 1'b1; redir_s = 1'b0; rpc_s = '0; ready_s = 1'b1; force_gnt_s = 1'b0;
    i_rst = 1'b1; i_en = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    bus.ready_i = 1'b1; bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;

    // Reset state, with fetch enabled so the request gating is exercised.
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("rst");

    // Streaming with 1-cycle memory.
    i_rst = 1'b0;
    tick();
    check_eq("first_req", 32'(req_log[cyc]), 32'd1);
    check_eq("first_addr", addr_log[cyc], 32'h0000_0000);
    run(9);
    check_eq("stream_valid_cycles", 32'(vcnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("stream_pc%0d", i), obs_pc_at(i), 32'(4 * i));
      check_eq($sformatf("stream_ins%0d", i), obs_ins_at(i), mem_word(32'(4 * i)));
    end

    // Decode stall: exactly FIFO_DEPTH grants, then resume in order.
    obs_pc.delete(); obs_ins.delete();
    en_s = 1'b0;
    run(4);
    en_s = 1'b1; ready_s = 1'b0; gcnt = 0;
    run(10);
    check_eq("stall_grants", 32'(gcnt), 32'd4);
    check_eq("stall_req_low", 32'(req_log[cyc]), 32'd0);
    check_eq("stall_valid", 32'(valid_log[cyc]), 32'd1);
    r = cyc + 1;
    ready_s = 1'b1;
    run(12);
    check_eq("release_req_same", 32'(req_log[r]), 32'd0);
    check_eq("release_req_next", 32'(req_log[r + 1]), 32'd1);
    check_eq("resume_count", 32'(obs_pc.size()), 32'd14);
    for (int i = 0; i < 14; i++) begin
      check_eq($sformatf("resume_pc%0d", i), obs_pc_at(i), 32'h20 + 32'(4 * i));
    end

    // Redirect with two requests outstanding at 3-cycle latency.
    en_s = 1'b0;
    run(6);
    obs_pc.delete(); obs_ins.delete();
    lat = 3;
    c = cyc + 1;
    en_s = 1'b1;
    run(2);
    en_s = 1'b0; redir_s = 1'b1; rpc_s = 32'h100;
    run(1);
    redir_s = 1'b0; en_s = 1'b1;
    run(10);
    check_eq("redir_valid_next", 32'(valid_log[c + 3]), 32'd0);
    check_eq("redir_drain_req", 32'(req_log[c + 3]), 32'd0);
    check_eq("redir_new_req", 32'(req_log[c + 5]), 32'd1);
    check_eq("redir_new_addr", addr_log[c + 5], 32'h100);
    check_eq("redir_pc0", obs_pc_at(0), 32'h100);
    check_eq("redir_ins0", obs_ins_at(0), mem_word(32'h100));
    check_eq("redir_pc1", obs_pc_at(1), 32'h104);

    // Redirect coinciding with a grant and a response; low pc bits ignored.
    en_s = 1'b0;
    run(8);
    obs_pc.delete(); obs_ins.delete();
    lat = 1;
    d = cyc + 1;
    en_s = 1'b1;
    run(1);
    redir_s = 1'b1; rpc_s = 32'h203; force_gnt_s = 1'b1;
    run(1);
    redir_s = 1'b0; force_gnt_s = 1'b0;
    run(7);
    check_eq("coinc_drain_req", 32'(req_log[d + 2]), 32'd0);
    check_eq("coinc_new_req", 32'(req_log[d + 3]), 32'd1);
    check_eq("coinc_new_addr", addr_log[d + 3], 32'h200);
    check_eq("coinc_pc0", obs_pc_at(0), 32'h200);
    check_eq("coinc_pc1", obs_pc_at(1), 32'h204);

    // Back-to-back redirects while draining: the later target wins.
    en_s = 1'b0;
    run(8);
    obs_pc.delete(); obs_ins.delete();
    lat = 3;
    e = cyc + 1;
    en_s = 1'b1;
    run(2);
    redir_s = 1'b1; rpc_s = 32'h40;
    run(1);
    rpc_s = 32'h80;
    run(1);
    redir_s = 1'b0;
    run(12);
    check_eq("b2b_drain_req", 32'(req_log[e + 4]), 32'd0);
    check_eq("b2b_new_req", 32'(req_log[e + 5]), 32'd1);
    check_eq("b2b_new_addr", addr_log[e + 5], 32'h80);
    check_eq("b2b_pc0", obs_pc_at(0), 32'h80);
    check_eq("b2b_pc1", obs_pc_at(1), 32'h84);

    // Asynchronous reset with the buffer half full.
    en_s = 1'b0;
    run(8);
    lat = 1; ready_s = 1'b0; en_s = 1'b1;
    run(2);
    en_s = 1'b0;
    run(2);
    check_eq("pre_rst_valid", 32'(bus.valid_o), 32'd1);
    i_rst = 1'b1;
    mq_addr.delete(); mq_due.delete();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    en_s = 1'b1; ready_s = 1'b1;
    obs_pc.delete(); obs_ins.delete();
    tick();
    check_eq("refetch_req", 32'(req_log[cyc]), 32'd1);
    check_eq("refetch_addr", addr_log[cyc], 32'h0000_0000);
    run(5);
    check_eq("refetch_pc0", obs_pc_at(0), 32'h0);
    check_eq("refetch_pc1", obs_pc_at(1), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
